uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10417, meaning clk cycles per UART bit (100 MHz / 9600 baud); legal range >= 2.
REQ-002 SHALL provide parameter DEPTH, default 8, meaning FIFO entries; a power of 2, >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  byte to queue for transmission.
REQ-006 SHALL have port wr_en  input  1  one-cycle write strobe, same format as the receiver's char/en pair.
REQ-007 SHALL have port tx  output  1  serial line, 8N1, idle high, drives RsTx.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port full  output  1  high when FIFO count == DEPTH.
REQ-010 SHALL have port empty  output  1  high when FIFO count == 0.
REQ-011 SHALL have port overflow  output  1  sticky; set when a write is dropped.

Function
REQ-012 A write SHALL be accepted when wr_en=1 and full=0 (the registered value at that edge); the byte is stored and count increments at that edge.
REQ-013 A write with full=1 SHALL be dropped, leave FIFO contents unchanged and set overflow=1 at the next edge; a pop in the same cycle does not rescue it.
REQ-014 Simultaneous accepted write and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 full, empty and busy SHALL be registered or derived only from registered state, with no combinational path from wr_en.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-017 IDLE: tx=1; if empty=0, pop the head byte into an 8-bit shift register, clear the baud counter and bit index, and go to START.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: send 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; go to STOP after bit 7.
REQ-020 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
REQ-021 A frame SHALL be exactly 10*CLKS_PER_BIT cycles; between back-to-back frames IDLE SHALL last exactly 1 cycle.
REQ-022 tx SHALL be driven from a flop, glitch-free.
REQ-023 Latency: a byte accepted into an empty FIFO with the FSM in IDLE at edge N SHALL produce the tx falling edge at edge N+2.
REQ-024 The baud counter SHALL be wide enough for CLKS_PER_BIT-1, count 0..CLKS_PER_BIT-1 and reset to 0 at each bit boundary.
REQ-025 Writes SHALL be accepted during any FSM state; a byte is never popped except in IDLE.

Reset
REQ-026 rst=1 at an edge SHALL force tx=1, busy=0, empty=1, full=0 and overflow=0, clear the pointers, count, baud counter and bit index, and put the FSM in IDLE.
REQ-027 Reset SHALL abort any frame mid-bit, with tx high from the edge after rst is sampled, and SHALL discard queued bytes; writes in a reset cycle SHALL be ignored.

Verification (CLKS_PER_BIT=4, DEPTH=8)
REQ-028 Write 0x41 at edge N -> tx low during N+2..N+5, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; busy low at N+42.
REQ-029 Three consecutive writes 0x55, 0xAA, 0x0F -> three correct frames, each followed by 1 IDLE cycle; empty=1 once the third frame has popped.
REQ-030 Nine writes in 9 consecutive cycles with the FSM busy -> full=1 after the 8th write, 9th byte dropped, overflow=1 (sticky), 8 frames transmitted in order.
REQ-031 Assert rst during DATA bit 3 -> tx=1 next cycle, empty=1, overflow=0; a following write of 0xFF -> clean frame 0,1x8,1.
REQ-032 Write 0x00 while a frame is in STOP -> 1 IDLE cycle, then start bit plus 8 zero bits (36 low cycles), then stop.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Handshake: a write is taken on any rising edge where wr_en=1 and the
// registered full flag is 0; a write while full is dropped and latches the
// sticky overflow flag. There is no backpressure beyond full/overflow.
// The transmitter pops the FIFO head only from IDLE, so back-to-back frames
// are separated by exactly one IDLE cycle. tx is a flop that follows the
// state one cycle later, which puts the start bit two edges after the write.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;
  logic          pop;
  logic          bit_done;

  // Status flags come only from registered count and state.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE) || !empty;
  assign push     = wr_en && !full;
  assign pop      = (state == IDLE) && !empty;
  assign bit_done = (baud == CW'(CLKS_PER_BIT - 1));

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Transmit FSM with registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            baud    <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_done) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_done) begin
            baud  <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + CW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
